// File: rtl/boot_pkg.sv
// Shared definitions for the serial boot loader: framing FSM encoding,
// UART receiver states, sync byte and length-field width.
package boot_pkg;

  localparam int LEN_W = 16;
  localparam logic [7:0] SYNC_BYTE = 8'h55;

  typedef enum logic [2:0] {
    S_SYNC   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_SUM    = 3'd4,
    S_RUN    = 3'd5
  } boot_state_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_START = 2'd1,
    R_DATA  = 2'd2,
    R_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, falling-edge start detect with
// half-bit glitch re-check, centre sampling, one-cycle byte_valid/frame_err.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic       frame_err,
  output logic [7:0] byte_data
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]       sync_r;
  logic             rx_d_r;
  logic             rx_s;
  rx_state_t        state_r;
  rx_state_t        next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             byte_valid_r;
  logic             frame_err_r;
  logic             tick_s;

  assign rx_s       = sync_r[1];
  assign byte_valid = byte_valid_r;
  assign frame_err  = frame_err_r;
  assign byte_data  = shift_r;

  // Input synchronizer plus one delayed copy for edge detection
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_r <= 2'b11;
      rx_d_r <= 1'b1;
    end else begin
      sync_r <= {sync_r[0], rx};
      rx_d_r <= sync_r[1];
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= R_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Sample-point decode: half bit in START, full bit in DATA/STOP
  always_comb begin
    tick_s = 1'b0;
    case (state_r)
      R_START:        tick_s = (cnt_r == HALF_C);
      R_DATA, R_STOP: tick_s = (cnt_r == FULL_C);
      default:        tick_s = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      R_IDLE: begin
        if (rx_d_r && !rx_s) next_s = R_START;
        else                 next_s = R_IDLE;
      end
      R_START: begin
        if (tick_s) next_s = rx_s ? R_IDLE : R_DATA;
        else        next_s = R_START;
      end
      R_DATA: begin
        if (tick_s && (bit_idx_r == 3'd7)) next_s = R_STOP;
        else                               next_s = R_DATA;
      end
      R_STOP: begin
        if (tick_s) next_s = R_IDLE;
        else        next_s = R_STOP;
      end
      default: next_s = R_IDLE;
    endcase
  end

  // Bit timer, shift register and one-cycle result strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r        <= {CNT_W{1'b0}};
      bit_idx_r    <= 3'd0;
      shift_r      <= 8'd0;
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
    end else begin
      cnt_r        <= (state_r == R_IDLE || tick_s) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
      byte_valid_r <= 1'b0;
      frame_err_r  <= 1'b0;
      if (state_r == R_START) bit_idx_r <= 3'd0;
      if (state_r == R_DATA && tick_s) begin
        shift_r   <= {rx_s, shift_r[7:1]};
        bit_idx_r <= bit_idx_r + 3'd1;
      end
      if (state_r == R_STOP && tick_s) begin
        byte_valid_r <= rx_s;
        frame_err_r  <= ~rx_s;
      end
    end
  end

endmodule

// File: rtl/boot_loader.sv
// Serial image loader: parses 55/LEN/payload[/CHK] frames, writes core memory,
// releases core reset on success. Checksum stage enabled by BOOT_LOADER_CHECKSUM_EN.
module boot_loader
  import boot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int MEM_BYTES    = 4096,
  parameter int ADDR_W       = 12
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              core_reset_n,
  output logic              busy,
  output logic              err
);

  localparam logic [LEN_W-1:0] MAX_LEN_C = LEN_W'(MEM_BYTES);

  logic              byte_valid_s;
  logic              frame_err_s;
  logic [7:0]        byte_data_s;
  boot_state_t       state_r;
  boot_state_t       next_s;
  logic [7:0]        len_lo_r;
  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  len_s;
  logic [LEN_W-1:0]  cnt_r;
`ifdef BOOT_LOADER_CHECKSUM_EN
  logic [7:0]        sum_r;
`endif
  logic              err_set_s;
  logic              err_clr_s;
  logic              rel_s;
  logic              busy_s;
  logic              we_s;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [7:0]        mem_wdata_r;
  logic              core_reset_n_r;
  logic              busy_r;
  logic              err_r;

  assign len_s        = {byte_data_s, len_lo_r};
  assign mem_we       = mem_we_r;
  assign mem_addr     = mem_addr_r;
  assign mem_wdata    = mem_wdata_r;
  assign core_reset_n = core_reset_n_r;
  assign busy         = busy_r;
  assign err          = err_r;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_valid (byte_valid_s),
    .frame_err  (frame_err_s),
    .byte_data  (byte_data_s)
  );

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_SYNC;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state logic with error set/clear requests
  always_comb begin
    next_s    = state_r;
    err_set_s = 1'b0;
    err_clr_s = 1'b0;
    case (state_r)
      S_SYNC: begin
        if (byte_valid_s && (byte_data_s == SYNC_BYTE)) begin
          next_s    = S_LEN_LO;
          err_clr_s = 1'b1;
        end else begin
          next_s = S_SYNC;
        end
      end
      S_LEN_LO: begin
        if (frame_err_s) begin
          next_s    = S_SYNC;
          err_set_s = 1'b1;
        end else if (byte_valid_s) begin
          next_s = S_LEN_HI;
        end else begin
          next_s = S_LEN_LO;
        end
      end
      S_LEN_HI: begin
        if (frame_err_s || (byte_valid_s && (len_s > MAX_LEN_C))) begin
          next_s    = S_SYNC;
          err_set_s = 1'b1;
        end else if (byte_valid_s && (len_s == {LEN_W{1'b0}})) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          next_s = S_SUM;
`else
          next_s = S_RUN;
`endif
        end else if (byte_valid_s) begin
          next_s = S_DATA;
        end else begin
          next_s = S_LEN_HI;
        end
      end
      S_DATA: begin
        if (frame_err_s) begin
          next_s    = S_SYNC;
          err_set_s = 1'b1;
        end else if (byte_valid_s && (cnt_r == len_r - LEN_W'(1))) begin
`ifdef BOOT_LOADER_CHECKSUM_EN
          next_s = S_SUM;
`else
          next_s = S_RUN;
`endif
        end else begin
          next_s = S_DATA;
        end
      end
`ifdef BOOT_LOADER_CHECKSUM_EN
      S_SUM: begin
        if (frame_err_s || (byte_valid_s && (byte_data_s != sum_r))) begin
          next_s    = S_SYNC;
          err_set_s = 1'b1;
        end else if (byte_valid_s) begin
          next_s = S_RUN;
        end else begin
          next_s = S_SUM;
        end
      end
`endif
      S_RUN:   next_s = S_RUN;
      default: next_s = S_SYNC;
    endcase
  end

  // Output decode: write strobe, core release, busy
  always_comb begin
    we_s = (state_r == S_DATA) && byte_valid_s;
`ifdef BOOT_LOADER_CHECKSUM_EN
    rel_s = (next_s == S_RUN);
`else
    // Release trails the last write by one cycle; an empty image releases directly
    rel_s = (state_r == S_RUN) || ((state_r == S_LEN_HI) && (next_s == S_RUN));
`endif
    busy_s = (next_s == S_LEN_LO) || (next_s == S_LEN_HI) || (next_s == S_DATA) ||
             (next_s == S_SUM) || ((next_s == S_RUN) && !rel_s);
  end

  // Counters, checksum, memory port and status registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_lo_r       <= 8'd0;
      len_r          <= {LEN_W{1'b0}};
      cnt_r          <= {LEN_W{1'b0}};
`ifdef BOOT_LOADER_CHECKSUM_EN
      sum_r          <= 8'd0;
`endif
      mem_we_r       <= 1'b0;
      mem_addr_r     <= {ADDR_W{1'b0}};
      mem_wdata_r    <= 8'd0;
      core_reset_n_r <= 1'b0;
      busy_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      if (err_clr_s) begin
        cnt_r <= {LEN_W{1'b0}};
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_r <= 8'd0;
`endif
      end
      if (state_r == S_LEN_LO && byte_valid_s) len_lo_r <= byte_data_s;
      if (state_r == S_LEN_HI && byte_valid_s) len_r <= len_s;
      mem_we_r <= we_s;
      if (we_s) begin
        mem_addr_r  <= cnt_r[ADDR_W-1:0];
        mem_wdata_r <= byte_data_s;
        cnt_r       <= cnt_r + LEN_W'(1);
`ifdef BOOT_LOADER_CHECKSUM_EN
        sum_r       <= sum_r + byte_data_s;
`endif
      end
      core_reset_n_r <= rel_s;
      busy_r         <= busy_s;
      if (err_set_s)      err_r <= 1'b1;
      else if (err_clr_s) err_r <= 1'b0;
    end
  end

endmodule
